// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and pipeline-sequencing controller for the 5-stage RISC-V core.
//
// Generates stall/flush controls for the PC and the F2D, D2E, E2M and M2W pipeline
// registers, E-stage forwarding selects, sequences the multi-cycle mul/div unit in E,
// holds the pipe on data-memory wait states, and keeps stall/flush performance counters.
//
// Ports:
//   i_clk, i_rst                 clock; synchronous active-high reset
//   i_rs1_d, i_rs2_d             source regs of the instruction in D
//   i_rs1_e, i_rs2_e             source regs of the instruction in E
//   i_rd_e, i_rd_m, i_rd_w       destination regs in E/M/W
//   i_result_src_e0              instruction in E is a load
//   i_reg_write_m, i_reg_write_w instruction in M/W writes the regfile
//   i_pc_src_e                   taken branch/jump resolved in E
//   i_md_req_e                   instruction in E is mul/div
//   i_mem_req_m, i_mem_ready_m   M-stage data-memory access / memory ready
//   o_stall_f..o_stall_m         hold PC, F2D, D2E, E2M
//   o_flush_d..o_flush_w         bubble into the D/E/M/W register
//   o_forward_a_e, o_forward_b_e 00=regfile, 10=ALUResultM, 01=ResultW
//   o_md_busy_e, o_md_done_e     mul/div FSM in BUSY / DONE
//   o_stall_cycles               cycles with o_stall_f=1
//   o_flush_count                cycles with o_flush_d=1
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_d,
  input  logic [4:0]  i_rs2_d,
  input  logic [4:0]  i_rs1_e,
  input  logic [4:0]  i_rs2_e,
  input  logic [4:0]  i_rd_e,
  input  logic [4:0]  i_rd_m,
  input  logic [4:0]  i_rd_w,
  input  logic        i_result_src_e0,
  input  logic        i_reg_write_m,
  input  logic        i_reg_write_w,
  input  logic        i_pc_src_e,
  input  logic        i_md_req_e,
  input  logic        i_mem_req_m,
  input  logic        i_mem_ready_m,
  output logic        o_stall_f,
  output logic        o_stall_d,
  output logic        o_stall_e,
  output logic        o_stall_m,
  output logic        o_flush_d,
  output logic        o_flush_e,
  output logic        o_flush_m,
  output logic        o_flush_w,
  output logic [1:0]  o_forward_a_e,
  output logic [1:0]  o_forward_b_e,
  output logic        o_md_busy_e,
  output logic        o_md_done_e,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  localparam int unsigned CntW = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e       r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [31:0]     r_stall_cycles, r_flush_count;

  logic w_mem_st, w_md_st, w_lw_st, w_idle, w_busy;

  assign w_idle   = (r_state == StIdle);
  assign w_busy   = (r_state == StBusy);
  assign w_mem_st = i_mem_req_m & ~i_mem_ready_m;
  // A fresh request stalls in the same cycle it is seen, before the FSM leaves IDLE.
  assign w_md_st  = (w_idle & i_md_req_e) | w_busy;
  // A taken branch squashes the dependent instruction in D, so load-use yields to it.
  assign w_lw_st  = i_result_src_e0 & (i_rd_e != 5'd0) &
                    ((i_rd_e == i_rs1_d) | (i_rd_e == i_rs2_d)) & ~i_pc_src_e;

  // Mul/div sequencer; everything holds while memory is waiting.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!w_mem_st) begin
      case (r_state)
        StIdle: begin
          if (i_md_req_e) begin
            w_state_next = StBusy;
            w_cnt_next   = CntW'(MD_LAT - 1);
          end
        end
        StBusy: begin
          if (r_cnt == CntW'(1)) begin
            w_state_next = StDone;
          end else begin
            w_cnt_next = r_cnt - CntW'(1);
          end
        end
        // The mul/div instruction is still in E here, so its request is not a new op.
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Stall/flush outputs; all forced low while reset is asserted.
  always_comb begin
    o_stall_f   = 1'b0;
    o_stall_d   = 1'b0;
    o_stall_e   = 1'b0;
    o_stall_m   = 1'b0;
    o_flush_d   = 1'b0;
    o_flush_e   = 1'b0;
    o_flush_m   = 1'b0;
    o_flush_w   = 1'b0;
    o_md_busy_e = 1'b0;
    o_md_done_e = 1'b0;
    if (!i_rst) begin
      o_stall_f   = w_mem_st | w_md_st | w_lw_st;
      o_stall_d   = w_mem_st | w_md_st | w_lw_st;
      o_stall_e   = w_mem_st | w_md_st;
      o_stall_m   = w_mem_st;
      // A branch held in E by a stall flushes on the first unstalled cycle.
      o_flush_d   = i_pc_src_e & ~w_mem_st & ~w_md_st;
      o_flush_e   = (w_lw_st | i_pc_src_e) & ~w_mem_st & ~w_md_st;
      o_flush_m   = w_md_st & ~w_mem_st;
      o_flush_w   = w_mem_st;
      o_md_busy_e = w_busy;
      o_md_done_e = (r_state == StDone);
    end
  end

  // Forwarding: M beats W, x0 is never forwarded.
  always_comb begin
    o_forward_a_e = 2'b00;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs1_e)) begin
      o_forward_a_e = 2'b10;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs1_e)) begin
      o_forward_a_e = 2'b01;
    end
  end

  always_comb begin
    o_forward_b_e = 2'b00;
    if (i_reg_write_m && (i_rd_m != 5'd0) && (i_rd_m == i_rs2_e)) begin
      o_forward_b_e = 2'b10;
    end else if (i_reg_write_w && (i_rd_w != 5'd0) && (i_rd_w == i_rs2_e)) begin
      o_forward_b_e = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (o_stall_f) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (o_flush_d) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_LAT=4). Expected output vectors are queued as
// stimulus is applied and popped for comparison half a cycle later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        load_e, regw_m, regw_w, pcsrc, md_req, mem_req, mem_ready;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic [1:0]  fwd_a, fwd_b;
  logic        md_busy, md_done;
  logic [31:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rs1_d         (rs1_d),
    .i_rs2_d         (rs2_d),
    .i_rs1_e         (rs1_e),
    .i_rs2_e         (rs2_e),
    .i_rd_e          (rd_e),
    .i_rd_m          (rd_m),
    .i_rd_w          (rd_w),
    .i_result_src_e0 (load_e),
    .i_reg_write_m   (regw_m),
    .i_reg_write_w   (regw_w),
    .i_pc_src_e      (pcsrc),
    .i_md_req_e      (md_req),
    .i_mem_req_m     (mem_req),
    .i_mem_ready_m   (mem_ready),
    .o_stall_f       (stall_f),
    .o_stall_d       (stall_d),
    .o_stall_e       (stall_e),
    .o_stall_m       (stall_m),
    .o_flush_d       (flush_d),
    .o_flush_e       (flush_e),
    .o_flush_m       (flush_m),
    .o_flush_w       (flush_w),
    .o_forward_a_e   (fwd_a),
    .o_forward_b_e   (fwd_b),
    .o_md_busy_e     (md_busy),
    .o_md_done_e     (md_done),
    .o_stall_cycles  (stall_cycles),
    .o_flush_count   (flush_count)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, regw_m, regw_w, pcsrc, md_req, mem_req, mem_ready;
  } stim_t;

  // Order: stall F D E M, flush D E M W, busy, done, fwd A, fwd B.
  logic [13:0] obs;
  assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                md_busy, md_done, fwd_a, fwd_b};

  logic [13:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_stall, mdl_flush;

  // Bit patterns for the stall/flush byte.
  localparam logic [7:0] SfNone = 8'b0000_0000;
  localparam logic [7:0] SfLdU  = 8'b1100_0100;
  localparam logic [7:0] SfBr   = 8'b0000_1100;
  localparam logic [7:0] SfMd   = 8'b1110_0010;
  localparam logic [7:0] SfMem  = 8'b1111_0001;

  function automatic logic [13:0] ex(input logic [7:0] sf, input logic bz, input logic dn,
                                     input logic [1:0] fa, input logic [1:0] fb);
    return {sf, bz, dn, fa, fb};
  endfunction

  function automatic stim_t idle_stim();
    stim_t t;
    t = '0;
    t.mem_ready = 1'b1;
    return t;
  endfunction

  task automatic apply(input stim_t t);
    rst = t.rst; rs1_d = t.rs1_d; rs2_d = t.rs2_d; rs1_e = t.rs1_e; rs2_e = t.rs2_e;
    rd_e = t.rd_e; rd_m = t.rd_m; rd_w = t.rd_w; load_e = t.load_e; regw_m = t.regw_m;
    regw_w = t.regw_w; pcsrc = t.pcsrc; md_req = t.md_req; mem_req = t.mem_req;
    mem_ready = t.mem_ready;
  endtask

  // Counter model advances on the posedge that follows each sampled cycle.
  task automatic model_step(input logic r, input logic [13:0] e);
    if (r) begin
      mdl_stall = 32'd0;
      mdl_flush = 32'd0;
    end else begin
      mdl_stall = mdl_stall + {31'd0, e[13]};
      mdl_flush = mdl_flush + {31'd0, e[9]};
    end
  endtask

  task automatic test_reset();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.rst = 1'b1; t.load_e = 1'b1; t.rd_e = 5'd5; t.rs1_d = 5'd5;
    t.pcsrc = 1'b1; t.md_req = 1'b1; t.mem_req = 1'b1; t.mem_ready = 1'b0;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL reset[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL reset[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.load_e = 1'b1; t.rd_e = 5'd5; t.rs1_d = 5'd5;
    s.push_back(t); e.push_back(ex(SfLdU, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.load_e = 1'b1; t.rd_e = 5'd12; t.rs2_d = 5'd12; t.rs1_d = 5'd3;
    s.push_back(t); e.push_back(ex(SfLdU, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.load_e = 1'b1; t.rd_e = 5'd0; t.rs1_d = 5'd0;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.load_e = 1'b0; t.rd_e = 5'd5; t.rs1_d = 5'd5;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL load_use[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL load_use[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.pcsrc = 1'b1;
    s.push_back(t); e.push_back(ex(SfBr, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.pcsrc = 1'b1; t.load_e = 1'b1; t.rd_e = 5'd5; t.rs1_d = 5'd5;
    s.push_back(t); e.push_back(ex(SfBr, 0, 0, 2'b00, 2'b00));
    // Branch held by a memory wait, then flushed once memory is ready.
    t = idle_stim(); t.pcsrc = 1'b1; t.mem_req = 1'b1; t.mem_ready = 1'b0;
    s.push_back(t); e.push_back(ex(SfMem, 0, 0, 2'b00, 2'b00));
    s.push_back(t); e.push_back(ex(SfMem, 0, 0, 2'b00, 2'b00));
    t.mem_ready = 1'b1;
    s.push_back(t); e.push_back(ex(SfBr, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL branch[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL branch[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_forwarding();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.rd_m = 5'd7; t.rd_w = 5'd7; t.regw_m = 1'b1; t.regw_w = 1'b1;
    t.rs1_e = 5'd7; t.rs2_e = 5'd3;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b10, 2'b00));
    t.rd_m = 5'd0;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b01, 2'b00));
    t.rd_w = 5'd0; t.rs1_e = 5'd0; t.rs2_e = 5'd0;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.rd_m = 5'd9; t.regw_m = 1'b1; t.rd_w = 5'd7; t.regw_w = 1'b1;
    t.rs1_e = 5'd7; t.rs2_e = 5'd9;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b01, 2'b10));
    t.regw_m = 1'b0; t.regw_w = 1'b0;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL forwarding[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_muldiv();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.md_req = 1'b1;
    s.push_back(t); e.push_back(ex(SfMd, 0, 0, 2'b00, 2'b00));
    for (int k = 0; k < 3; k++) begin
      s.push_back(t); e.push_back(ex(SfMd, 1, 0, 2'b00, 2'b00));
    end
    // Request still high in DONE: must not restart.
    s.push_back(t); e.push_back(ex(SfNone, 0, 1, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL muldiv[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL muldiv[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_mem_wait();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.md_req = 1'b1;
    s.push_back(t); e.push_back(ex(SfMd, 0, 0, 2'b00, 2'b00));
    t.mem_req = 1'b1; t.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s.push_back(t); e.push_back(ex(SfMem, 1, 0, 2'b00, 2'b00));
    end
    t.mem_req = 1'b0; t.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s.push_back(t); e.push_back(ex(SfMd, 1, 0, 2'b00, 2'b00));
    end
    s.push_back(t); e.push_back(ex(SfNone, 0, 1, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL mem_wait[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL mem_wait[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.md_req = 1'b1;
    for (int op = 0; op < 2; op++) begin
      s.push_back(t); e.push_back(ex(SfMd, 0, 0, 2'b00, 2'b00));
      for (int k = 0; k < 3; k++) begin
        s.push_back(t); e.push_back(ex(SfMd, 1, 0, 2'b00, 2'b00));
      end
      s.push_back(t); e.push_back(ex(SfNone, 0, 1, 2'b00, 2'b00));
    end
    t = idle_stim(); t.load_e = 1'b1; t.rd_e = 5'd8; t.rs2_d = 5'd8;
    s.push_back(t); e.push_back(ex(SfLdU, 0, 0, 2'b00, 2'b00));
    t = idle_stim(); t.pcsrc = 1'b1;
    s.push_back(t); e.push_back(ex(SfBr, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL back_to_back[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL back_to_back[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  task automatic test_reset_mid_op();
    stim_t s[$]; logic [13:0] e[$]; stim_t t; logic [13:0] x;
    t = idle_stim(); t.md_req = 1'b1;
    s.push_back(t); e.push_back(ex(SfMd, 0, 0, 2'b00, 2'b00));
    s.push_back(t); e.push_back(ex(SfMd, 1, 0, 2'b00, 2'b00));
    // Counter is at 2 here; reset must abort the op.
    t.rst = 1'b1;
    s.push_back(t); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    s.push_back(idle_stim()); e.push_back(ex(SfNone, 0, 0, 2'b00, 2'b00));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
      @(negedge clk); x = exp_q.pop_front();
      checks++;
      if (obs !== x) begin
        errors++; $display("FAIL reset_mid[%0d] outputs got=%b exp=%b", i, obs, x);
      end
      checks++;
      if (stall_cycles !== mdl_stall || flush_count !== mdl_flush) begin
        errors++;
        $display("FAIL reset_mid[%0d] counters got=%0d/%0d exp=%0d/%0d", i, stall_cycles,
                 flush_count, mdl_stall, mdl_flush);
      end
      model_step(s[i].rst, x);
    end
  endtask

  initial begin
    stim_t t;
    t = idle_stim(); t.rst = 1'b1;
    apply(t);
    mdl_stall = 32'd0;
    mdl_flush = 32'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_forwarding();
    test_muldiv();
    test_mem_wait();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
